faerie_addr_unit: RTL and testbench

- Address/program-counter stage directly downstream of the Faerie control unit.
- Consumes the control unit's per-cycle strobes: pc_addr, set_al, set_ah, zp_addr, inc_al, branch, re, we.
- Owns the 16-bit PC and the 16-bit address register AR = {AH, AL}.
- Drives the memory address bus every cycle, captures address bytes from memory read data, and performs PC increment and branch writes.

---
 rtl/faerie_addr_unit.sv | 98 +++++++++
 tb/tb_faerie_addr_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/faerie_addr_unit.sv
// Faerie address unit: owns the program counter and the address register
// AR = {AH, AL}. It forms the memory address every cycle, captures address
// bytes from memory read data and applies PC increments and branches.
module faerie_addr_unit #(
  parameter bit          sync_read    = 1'b1,
  parameter logic [15:0] reset_vector = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rdata,
  input  logic        re,
  input  logic        we,
  input  logic        pc_addr,
  input  logic        zp_addr,
  input  logic        set_al,
  input  logic        set_ah,
  input  logic        inc_al,
  input  logic        branch,
  input  logic        branch_cond,
  output logic [15:0] addr,
  output logic [15:0] pc,
  output logic [15:0] ar
);

  logic [15:0] pc_q, pc_d;
  logic [7:0]  al_q, al_d;
  logic [7:0]  ah_q, ah_d;
  logic        pend_al_q, pend_al_d;
  logic        pend_ah_q, pend_ah_d;

  logic        cap_al, cap_ah;
  logic [7:0]  eff_al, eff_ah;

  // Decide which address byte is landing from rdata this cycle. With a
  // synchronous memory the byte requested last cycle arrives now.
  always_comb begin
    cap_al = set_al;
    cap_ah = set_ah;
    if (sync_read) begin
      cap_al = pend_al_q;
      cap_ah = pend_ah_q;
    end
  end

  // Effective AR bypasses a landing byte straight from rdata so the cycle
  // that consumes AR can be the same cycle its byte arrives.
  always_comb begin
    eff_al = cap_al ? rdata : al_q;
    eff_ah = cap_ah ? rdata : ah_q;
  end

  // Address mux: PC first, then zero page, then the full AR.
  always_comb begin
    if (pc_addr) begin
      addr = pc_q;
    end else if (zp_addr) begin
      addr = {8'h00, eff_al};
    end else begin
      addr = {eff_ah, eff_al};
    end
  end

  // Next-state for AR, PC and the in-flight capture flags.
  always_comb begin
    // AL wraps within its byte; no carry into AH keeps zero-page pointers in page 0.
    al_d      = eff_al + {7'd0, inc_al};
    ah_d      = eff_ah;
    pend_al_d = sync_read & set_al;
    pend_ah_d = sync_read & set_ah;
    pc_d      = pc_q;
    if (branch && branch_cond) begin
      pc_d = {eff_ah, eff_al};
    end else if (pc_addr && (re || we)) begin
      pc_d = pc_q + 16'd1;
    end
  end

  // State registers; reset discards any read data still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= reset_vector;
      al_q      <= 8'h00;
      ah_q      <= 8'h00;
      pend_al_q <= 1'b0;
      pend_ah_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      al_q      <= al_d;
      ah_q      <= ah_d;
      pend_al_q <= pend_al_d;
      pend_ah_q <= pend_ah_d;
    end
  end

  assign pc = pc_q;
  assign ar = {eff_ah, eff_al};

endmodule

// File: tb/tb_faerie_addr_unit.sv
// Testbench for faerie_addr_unit (sync_read=1, reset_vector=16'h0200):
// directed scenarios plus randomized strobes against a reference model.
module tb_faerie_addr_unit;

  localparam logic [15:0] RV = 16'h0200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rdata = 8'h00;
  logic        re = 1'b0, we = 1'b0, pc_addr = 1'b0, zp_addr = 1'b0;
  logic        set_al = 1'b0, set_ah = 1'b0, inc_al = 1'b0;
  logic        branch = 1'b0, branch_cond = 1'b0;
  logic [15:0] addr, pc, ar;

  faerie_addr_unit #(.sync_read(1'b1), .reset_vector(RV)) dut (
    .clk(clk), .rst(rst), .rdata(rdata), .re(re), .we(we),
    .pc_addr(pc_addr), .zp_addr(zp_addr), .set_al(set_al), .set_ah(set_ah),
    .inc_al(inc_al), .branch(branch), .branch_cond(branch_cond),
    .addr(addr), .pc(pc), .ar(ar)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Reference model: architectural PC and AR plus the bytes that were
  // requested last cycle and therefore arrive on rdata this cycle.
  logic [15:0] m_pc;
  logic [7:0]  m_al, m_ah;
  bit          m_arrive_al, m_arrive_ah;
  bit          chk_en = 0;
  logic [15:0] last_addr, last_ar;

  // One bus cycle: drive strobes at negedge, compare outputs, then advance
  // the model across the following rising edge.
  task automatic cyc(input bit rs, input bit pa, input bit zp, input bit sal,
                     input bit sah, input bit inc, input bit br, input bit bc,
                     input bit r, input bit w, input logic [7:0] rd);
    logic [7:0]  v_al, v_ah;
    logic [15:0] exp_addr, exp_ar;
    @(negedge clk);
    rst = rs; pc_addr = pa; zp_addr = zp; set_al = sal; set_ah = sah;
    inc_al = inc; branch = br; branch_cond = bc; re = r; we = w; rdata = rd;
    #1;
    v_al = m_arrive_al ? rd : m_al;
    v_ah = m_arrive_ah ? rd : m_ah;
    exp_ar = {v_ah, v_al};
    if (pa)      exp_addr = m_pc;
    else if (zp) exp_addr = 16'h0000 + v_al;
    else         exp_addr = exp_ar;
    last_addr = addr;
    last_ar   = ar;
    if (chk_en) begin
      check_val("addr", addr, exp_addr);
      check_val("ar", ar, exp_ar);
      check_val("pc", pc, m_pc);
    end
    @(posedge clk);
    if (rs) begin
      m_pc = RV; m_al = 8'h00; m_ah = 8'h00;
      m_arrive_al = 0; m_arrive_ah = 0;
    end else begin
      if (br && bc)             m_pc = exp_ar;
      else if (pa && (r || w))  m_pc = (m_pc + 1) % 65536;
      m_al = (v_al + (inc ? 1 : 0)) % 256;
      m_ah = v_ah;
      m_arrive_al = sal;
      m_arrive_ah = sah;
    end
    #1;
  endtask

  // Idle cycle: nothing requested, rdata irrelevant.
  task automatic idle(input logic [7:0] rd);
    cyc(0,0,0,0,0,0,0,0,0,0, rd);
  endtask

  // Load AR = {hi, lo} via two synchronous captures, landing on idle cycles.
  task automatic load_ar(input logic [7:0] hi, input logic [7:0] lo);
    cyc(0,0,0,1,0,0,0,0,1,0, 8'h00);
    cyc(0,0,0,0,1,0,0,0,1,0, lo);
    idle(hi);
  endtask

  initial begin
    // Reset from unknown state
    cyc(1,0,0,0,0,0,0,0,0,0, 8'h00);
    cyc(1,0,0,0,0,0,0,0,0,0, 8'h00);
    chk_en = 1;
    check_val("rst_pc", pc, 16'h0200);
    check_val("rst_ar", ar, 16'h0000);

    // Three sequential fetches
    cyc(0,1,0,0,0,0,0,0,1,0, 8'h11);
    check_val("fetch0_addr", last_addr, 16'h0200);
    cyc(0,1,0,0,0,0,0,0,1,0, 8'h22);
    check_val("fetch1_addr", last_addr, 16'h0201);
    cyc(0,1,0,0,0,0,0,0,1,0, 8'h33);
    check_val("fetch2_addr", last_addr, 16'h0202);
    check_val("fetch_pc", pc, 16'h0203);

    // Absolute load from PC=0x0100
    cyc(0,0,0,1,0,0,0,0,1,0, 8'h00);
    cyc(0,0,0,0,1,0,0,0,1,0, 8'h00);
    cyc(0,0,0,0,0,0,1,1,0,0, 8'h01);
    check_val("abs_pc0", pc, 16'h0100);
    cyc(0,1,0,0,0,0,0,0,1,0, 8'hA9);   // insn fetch
    cyc(0,1,0,1,0,0,0,0,1,0, 8'h00);   // addr_1
    cyc(0,1,0,0,1,0,0,0,1,0, 8'h34);   // addr_2, low byte lands
    cyc(0,0,0,0,0,0,0,0,1,0, 8'h12);   // mem cycle, high byte lands
    check_val("abs_mem_addr", last_addr, 16'h1234);
    check_val("abs_ar", ar, 16'h1234);
    check_val("abs_pc", pc, 16'h0103);

    // Zero-page pointer with AL wrap
    cyc(0,0,0,1,0,0,0,0,1,0, 8'h00);
    idle(8'hFF);
    cyc(0,0,1,0,1,1,0,0,1,0, 8'h00);   // ptr_1
    check_val("zp1_addr", last_addr, 16'h00FF);
    cyc(0,0,1,1,0,0,0,0,1,0, 8'h56);   // ptr_2
    check_val("zp2_addr", last_addr, 16'h0000);
    idle(8'h78);
    check_val("zp_ar", last_ar, 16'h5678);

    // Branch
    load_ar(8'hAB, 8'hCD);
    cyc(0,0,0,0,0,0,1,0,0,0, 8'h00);
    check_val("br_nt_pc", pc, 16'h0103);
    cyc(0,0,0,0,0,0,1,1,0,0, 8'h00);
    check_val("br_t_pc", pc, 16'hABCD);
    cyc(0,1,0,0,0,0,1,1,1,0, 8'h00);
    check_val("br_pri_pc", pc, 16'hABCD);

    // PC wrap
    load_ar(8'hFF, 8'hFF);
    cyc(0,0,0,0,0,0,1,1,0,0, 8'h00);
    check_val("wrap_pc0", pc, 16'hFFFF);
    cyc(0,1,0,0,0,0,0,0,0,1, 8'h00);
    check_val("wrap_pc", pc, 16'h0000);

    // Reset while a capture is in flight
    load_ar(8'h00, 8'h00);
    cyc(0,1,0,1,0,0,0,0,1,0, 8'h00);
    cyc(1,0,0,0,0,0,0,0,0,0, 8'h44);
    idle(8'h99);
    check_val("rst_mid_ar_inflight", last_ar, 16'h0000);
    check_val("rst_mid_ar", ar, 16'h0000);
    check_val("rst_mid_pc", pc, RV);

    // Randomized strobes
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 31) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
          ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
